// File: rtl/birdwtch_reg_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : birdwtch_reg_arbiter
// Description : Two-port round-robin arbiter in front of the birdwatch
//               AXI4-Lite register slave (4 x 32-bit registers). Each
//               requester issues single-beat read/write commands over a
//               valid/ready port. Commands are serialised into AXI4-Lite
//               transactions, one outstanding at a time. The completion is
//               returned as a one-cycle response pulse to the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module birdwtch_reg_arbiter #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESET,

    // Requester command / response ports
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0]                req_we,
    input  logic [2*ADDR_WIDTH-1:0]   req_addr,
    input  logic [63:0]               req_wdata,
    output logic [1:0]                rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic [1:0]                rsp_resp,

    // AXI4-Lite write address channel
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,

    // AXI4-Lite write data channel
    output logic [31:0]               M_AXI_WDATA,
    output logic [3:0]                M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,

    // AXI4-Lite write response channel
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,

    // AXI4-Lite read address channel
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,

    // AXI4-Lite read data channel
    input  logic [31:0]               M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_wstrb_all = 4'hF;
    localparam logic [2:0] c_prot      = 3'b000;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD      = 3'd3,
        S_RD_RESP = 3'd4,
        S_RSP     = 3'd5
    } state_t;

    state_t                  r_state;

    // r_last is both the round-robin pointer and the owner of the transaction
    // in flight: it is loaded with the grant on every acceptance, so while a
    // command is outstanding it names the requester that must be answered.
    logic                    r_last;

    // AXI outputs are registered; the address/data registers double as the
    // latched copy of the accepted command.
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic                    r_awvalid;
    logic [31:0]             r_wdata;
    logic                    r_wvalid;
    logic                    r_bready;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic                    r_arvalid;
    logic                    r_rready;

    logic [1:0]              r_rsp_valid;
    logic [31:0]             r_rsp_rdata;
    logic [1:0]              r_rsp_resp;

    // ------------------------------------------------------------------------
    // Arbitration (combinational)
    // ------------------------------------------------------------------------
    logic                    w_grant;
    logic                    w_accept;
    logic                    w_sel_we;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [31:0]             w_sel_wdata;
    logic [ADDR_WIDTH-1:0]   w_axaddr;
    logic [1:0]              w_owner_onehot;
    logic                    w_aw_done;
    logic                    w_w_done;
    logic                    w_unused_addr_lsbs;

    // With both requesters pending the one that did not win last time goes
    // first; otherwise the single pending requester wins.
    assign w_grant  = (&req_valid) ? ~r_last : req_valid[1];

    // Acceptance only happens in IDLE; suppressed while reset is asserted so
    // that every output reads zero during reset.
    assign w_accept = (r_state == S_IDLE) && (|req_valid) && !ARESET;

    assign req_ready = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

    assign w_sel_we    = w_grant ? req_we[1] : req_we[0];
    assign w_sel_addr  = w_grant ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                 : req_addr[ADDR_WIDTH-1:0];
    assign w_sel_wdata = w_grant ? req_wdata[63:32] : req_wdata[31:0];

    // Registers are word-wide; the byte-lane bits are dropped so that an
    // unaligned request hits the word that contains it.
    assign w_axaddr           = {w_sel_addr[ADDR_WIDTH-1:2], 2'b00};
    assign w_unused_addr_lsbs = ^w_sel_addr[1:0];

    assign w_owner_onehot = r_last ? 2'b10 : 2'b01;

    // A write channel is finished once its valid has dropped or it is being
    // handshaken this cycle; AW and W may complete in either order.
    assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
    assign w_w_done  = !r_wvalid  || M_AXI_WREADY;

    // ------------------------------------------------------------------------
    // Transaction sequencer: arbitration, AXI channel handshakes, response
    // ------------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_last <= w_grant;
                        if (w_sel_we) begin
                            r_awaddr  <= w_axaddr;
                            r_awvalid <= 1'b1;
                            r_wdata   <= w_sel_wdata;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR;
                        end else begin
                            r_araddr  <= w_axaddr;
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD;
                        end
                    end
                end

                S_WR: begin
                    if (r_awvalid && M_AXI_AWREADY) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && M_AXI_WREADY) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_RESP;
                    end
                end

                S_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= w_owner_onehot;
                        r_rsp_rdata <= '0;
                        r_rsp_resp  <= M_AXI_BRESP;
                        r_state     <= S_RSP;
                    end
                end

                S_RD: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_RESP;
                    end
                end

                S_RD_RESP: begin
                    if (M_AXI_RVALID) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= w_owner_onehot;
                        r_rsp_rdata <= M_AXI_RDATA;
                        r_rsp_resp  <= M_AXI_RRESP;
                        r_state     <= S_RSP;
                    end
                end

                S_RSP: begin
                    // Response pulse is exactly one cycle; no grant here.
                    r_rsp_valid <= 2'b00;
                    r_rsp_rdata <= '0;
                    r_rsp_resp  <= 2'b00;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_awvalid   <= 1'b0;
                    r_wvalid    <= 1'b0;
                    r_bready    <= 1'b0;
                    r_arvalid   <= 1'b0;
                    r_rready    <= 1'b0;
                    r_rsp_valid <= 2'b00;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWPROT  = c_prot;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = c_wstrb_all;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARPROT  = c_prot;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;

endmodule
`default_nettype wire
